// File: rtl/gbt_frame_handler.sv
// -----------------------------------------------------------------------------
// gbt_frame_handler
//
// User-side peer of the GBT link wrapper, running on the 40 MHz frame clock.
//
// RX path: every clock a new 84-bit frame arrives. Stage 1 registers it and
// stage 2 checks its CRC and sequence number. A hunt/sync/lock tracker decides
// when the link is trustworthy. Payload is delivered only for good frames that
// are checked while the tracker is already LOCKED.
//
// TX path: every active clock emits one frame. The frame carries the offered
// payload if there is one, otherwise an idle frame (cmd 0, data 0).
//
// Frame layout (both directions): [83:80] seq, [79:72] cmd, [71:8] data,
// [7:0] crc. CRC-8: poly 0x07, init 0x00, over frame[83:8], MSB first.
//
// Optional feature macro: GBT_FRAME_CRC_EN
//   defined     : CRC generated on TX and checked on RX.
//   not defined : TX crc field is 8'h00, RX treats every CRC as ok and
//                 crc_err_cnt_o is tied to 0.
//
// Parameters:
//   SYNC_FRAMES  consecutive good frames required to declare lock
//   LOSS_FRAMES  consecutive bad frames, while locked, that drop lock
//   CNT_W        width of the saturating error counters
//
// Ports:
//   clk            frame clock (RX and TX share it)
//   reset          asynchronous, active-high reset
//   link_ready_i   GBT link ready
//   rx_ready_i     GBT RX ready
//   tx_ready_i     GBT TX ready
//   rx_frame_i     received frame, one per clock
//   rx_data_o      received payload (holds between strobes)
//   rx_cmd_o       received command (holds between strobes)
//   rx_valid_o     1-cycle strobe, rx_data_o/rx_cmd_o valid
//   locked_o       RX tracker in LOCKED
//   tx_data_i      payload to send
//   tx_cmd_i       command to send
//   tx_valid_i     payload offered
//   tx_accept_o    payload taken this cycle (combinational)
//   tx_frame_o     frame to the GBT transmitter (registered)
//   clear_cnt_i    synchronous clear of both error counters
//   crc_err_cnt_o  CRC error count, saturating
//   seq_err_cnt_o  sequence error count, saturating
//   rx_state_o     debug view of the RX tracker state
//                  (0 IDLE, 1 HUNT, 2 SYNC, 3 LOCKED)
//
// TX handshake: tx_valid_i/tx_accept_o. The payload on tx_cmd_i/tx_data_i is
// transferred in a cycle where tx_valid_i and tx_accept_o are both high.
// tx_accept_o is high exactly when the transmitter is active (tx_ready_i and
// link_ready_i) and tx_valid_i is high; it never depends on future cycles, so
// the source may hold or drop tx_valid_i freely. The accepted payload appears
// in tx_frame_o one clock later.
// -----------------------------------------------------------------------------
module gbt_frame_handler #(
  parameter int SYNC_FRAMES = 4,
  parameter int LOSS_FRAMES = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             link_ready_i,
  input  logic             rx_ready_i,
  input  logic             tx_ready_i,
  input  logic [83:0]      rx_frame_i,
  output logic [63:0]      rx_data_o,
  output logic [7:0]       rx_cmd_o,
  output logic             rx_valid_o,
  output logic             locked_o,
  input  logic [63:0]      tx_data_i,
  input  logic [7:0]       tx_cmd_i,
  input  logic             tx_valid_i,
  output logic             tx_accept_o,
  output logic [83:0]      tx_frame_o,
  input  logic             clear_cnt_i,
  output logic [CNT_W-1:0] crc_err_cnt_o,
  output logic [CNT_W-1:0] seq_err_cnt_o,
  output logic [1:0]       rx_state_o
);

  localparam int RUN_W  = $clog2(SYNC_FRAMES + 1);
  localparam int LOSS_W = $clog2(LOSS_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_SYNC   = 2'd2,
    ST_LOCKED = 2'd3
  } rx_state_t;

`ifdef GBT_FRAME_CRC_EN
  // Bit-serial CRC-8 (poly 0x07, init 0), MSB of the covered field first.
  function automatic logic [7:0] crc8(input logic [75:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 75; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // RX stage 1: register the incoming frame. While the link is down the stage
  // is emptied so that nothing stale is checked once the link returns.
  // ---------------------------------------------------------------------------
  logic        link_ok;
  logic [83:0] s1_frame;
  logic        s1_valid;

  assign link_ok = link_ready_i & rx_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_frame <= '0;
      s1_valid <= 1'b0;
    end else if (!link_ok) begin
      s1_frame <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_frame <= rx_frame_i;
      s1_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // RX stage 2: frame checks.
  // ---------------------------------------------------------------------------
  logic [3:0] s1_seq;
  logic       crc_ok;
  logic       seq_ok;
  logic       frame_good;
  logic       check;

  rx_state_t         state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [LOSS_W-1:0] bad_run_q, bad_run_d;
  logic [3:0]        exp_seq_q, exp_seq_d;
  logic              deliver;

  assign s1_seq = s1_frame[83:80];

`ifdef GBT_FRAME_CRC_EN
  assign crc_ok = (crc8(s1_frame[83:8]) == s1_frame[7:0]);
`else
  // The crc field is carried but deliberately ignored in this build.
  logic unused_crc_field;
  assign unused_crc_field = ^s1_frame[7:0];
  assign crc_ok = 1'b1;
`endif

  assign seq_ok     = (s1_seq == exp_seq_q);
  assign frame_good = crc_ok & seq_ok;
  // A frame is only judged once the tracker has left IDLE; the IDLE cycle
  // itself just arms the tracker.
  assign check      = s1_valid & (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // RX tracker: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      run_q     <= '0;
      bad_run_q <= '0;
      exp_seq_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      bad_run_q <= bad_run_d;
      exp_seq_q <= exp_seq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX tracker: next state. Losing link/rx ready overrides everything.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    bad_run_d = bad_run_q;
    exp_seq_d = exp_seq_q;
    deliver   = 1'b0;

    if (!link_ok) begin
      state_d   = ST_IDLE;
      run_d     = '0;
      bad_run_d = '0;
      exp_seq_d = '0;
    end else begin
      // Expected sequence always follows the last checked frame, so a single
      // slip in the stream costs exactly one error.
      if (check) begin
        exp_seq_d = s1_seq + 4'd1;
      end

      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_HUNT;
          run_d     = '0;
          bad_run_d = '0;
        end

        ST_HUNT: begin
          if (check && crc_ok) begin
            run_d     = RUN_W'(1);
            bad_run_d = '0;
            state_d   = (SYNC_FRAMES <= 1) ? ST_LOCKED : ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (check) begin
            if (frame_good) begin
              run_d = run_q + RUN_W'(1);
              if (run_d == RUN_W'(SYNC_FRAMES)) begin
                state_d   = ST_LOCKED;
                bad_run_d = '0;
              end
            end else begin
              state_d = ST_HUNT;
              run_d   = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (check) begin
            if (frame_good) begin
              bad_run_d = '0;
              deliver   = 1'b1;
            end else begin
              bad_run_d = bad_run_q + LOSS_W'(1);
              if (bad_run_d == LOSS_W'(LOSS_FRAMES)) begin
                state_d   = ST_HUNT;
                bad_run_d = '0;
                run_d     = '0;
              end
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign locked_o   = (state_q == ST_LOCKED);
  assign rx_state_o = state_q;

  // ---------------------------------------------------------------------------
  // RX outputs: strobe plus held payload.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_cmd_o   <= '0;
    end else begin
      rx_valid_o <= deliver;
      if (deliver) begin
        rx_cmd_o  <= s1_frame[79:72];
        rx_data_o <= s1_frame[71:8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error statistics. Only frames judged in SYNC or LOCKED count; a frame with
  // a CRC error is never also counted as a sequence error.
  // ---------------------------------------------------------------------------
  logic count_en;
  logic seq_err;

  assign count_en = link_ok & check & ((state_q == ST_SYNC) | (state_q == ST_LOCKED));
  assign seq_err  = count_en & crc_ok & ~seq_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_err_cnt_o <= '0;
    end else if (clear_cnt_i) begin
      seq_err_cnt_o <= '0;
    end else if (seq_err && (seq_err_cnt_o != '1)) begin
      seq_err_cnt_o <= seq_err_cnt_o + CNT_W'(1);
    end
  end

`ifdef GBT_FRAME_CRC_EN
  logic crc_err;
  assign crc_err = count_en & ~crc_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_err_cnt_o <= '0;
    end else if (clear_cnt_i) begin
      crc_err_cnt_o <= '0;
    end else if (crc_err && (crc_err_cnt_o != '1)) begin
      crc_err_cnt_o <= crc_err_cnt_o + CNT_W'(1);
    end
  end
`else
  assign crc_err_cnt_o = '0;
`endif

  // ---------------------------------------------------------------------------
  // TX path.
  // ---------------------------------------------------------------------------
  logic        tx_active;
  logic [3:0]  tx_seq_q;
  logic [75:0] tx_body;
  logic [7:0]  tx_crc;

  assign tx_active   = tx_ready_i & link_ready_i;
  assign tx_accept_o = tx_active & tx_valid_i;

  // Idle frames still carry a sequence number so the far end keeps its lock.
  assign tx_body = {tx_seq_q,
                    tx_accept_o ? tx_cmd_i  : 8'h00,
                    tx_accept_o ? tx_data_i : 64'h0};

`ifdef GBT_FRAME_CRC_EN
  assign tx_crc = crc8(tx_body);
`else
  assign tx_crc = 8'h00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_frame_o <= '0;
      tx_seq_q   <= '0;
    end else if (!tx_active) begin
      tx_frame_o <= '0;
      tx_seq_q   <= '0;
    end else begin
      tx_frame_o <= {tx_body, tx_crc};
      tx_seq_q   <= tx_seq_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_gbt_frame_handler.sv
module tb_gbt_frame_handler;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef GBT_FRAME_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic             clk;
  logic             rst;
  logic             link;
  logic             rxr;
  logic             txr;
  logic [83:0]      rx_frame;
  logic [63:0]      rx_data;
  logic [7:0]       rx_cmd;
  logic             rx_valid;
  logic             locked;
  logic [63:0]      tx_data;
  logic [7:0]       tx_cmd;
  logic             tx_valid;
  logic             tx_accept;
  logic [83:0]      tx_frame;
  logic             clear;
  logic [CNT_W-1:0] crc_cnt;
  logic [CNT_W-1:0] seq_cnt;
  logic [1:0]       rx_state;

  gbt_frame_handler #(
    .SYNC_FRAMES(4),
    .LOSS_FRAMES(8),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .link_ready_i  (link),
    .rx_ready_i    (rxr),
    .tx_ready_i    (txr),
    .rx_frame_i    (rx_frame),
    .rx_data_o     (rx_data),
    .rx_cmd_o      (rx_cmd),
    .rx_valid_o    (rx_valid),
    .locked_o      (locked),
    .tx_data_i     (tx_data),
    .tx_cmd_i      (tx_cmd),
    .tx_valid_i    (tx_valid),
    .tx_accept_o   (tx_accept),
    .tx_frame_o    (tx_frame),
    .clear_cnt_i   (clear),
    .crc_err_cnt_o (crc_cnt),
    .seq_err_cnt_o (seq_cnt),
    .rx_state_o    (rx_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          tests  = 0;
  int          errors = 0;
  logic [71:0] exp_q[$];
  logic [83:0] tx_exp_q[$];
  logic [71:0] mon_exp;
  logic [71:0] last_pl;
  logic [71:0] held_pl;
  logic [3:0]  rseq;
  logic [3:0]  tseq;
  int          exp_crc;
  int          exp_seqe;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // Reference CRC as polynomial long division of {body, 8'h00} by 0x107.
  function automatic logic [7:0] crc_ref(input logic [75:0] body);
    logic [83:0] r;
    r = {body, 8'h00};
    for (int i = 83; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic logic [83:0] mk_frame(input logic [3:0] seq, input logic [7:0] cmd,
                                           input logic [63:0] data, input bit bad);
    logic [75:0] body;
    logic [7:0]  c;
    body = {seq, cmd, data};
    c    = crc_ref(body);
    if (bad) c = c ^ 8'h01;
    return {body, c};
  endfunction

  // ---------------------------------------------------------------------------
  // RX driver tasks: each presents one frame for one clock.
  // ---------------------------------------------------------------------------
  task automatic send(input logic [3:0] seq, input bit bad, input bit expect_valid);
    logic [7:0]  cmd;
    logic [63:0] data;
    cmd      = 8'($urandom_range(255, 1));
    data     = {$urandom, $urandom};
    rx_frame = mk_frame(seq, cmd, data, bad);
    last_pl  = {cmd, data};
    if (expect_valid) exp_q.push_back({cmd, data});
    @(negedge clk);
  endtask

  task automatic good(input bit ev);
    send(rseq, 1'b0, ev);
    rseq = rseq + 4'd1;
  endtask

  task automatic bad_crc(input bit ev);
    send(rseq, 1'b1, ev);
    rseq = rseq + 4'd1;
  endtask

  // Sequence slip: skips one number, CRC correct.
  task automatic skip();
    send(rseq + 4'd1, 1'b0, 1'b0);
    rseq = rseq + 4'd2;
  endtask

  // ---------------------------------------------------------------------------
  // TX driver: one cycle, scoreboarded frame compared one clock later.
  // ---------------------------------------------------------------------------
  task automatic tx_cycle(input bit rdy, input bit v, input logic [7:0] c, input logic [63:0] d);
    logic        act;
    logic [75:0] body;
    logic [83:0] ef;
    txr      = rdy;
    tx_valid = v;
    tx_cmd   = c;
    tx_data  = d;
    act      = rdy & link;
    #1;
    check_eq("tx_accept", tx_accept, act & v);
    if (act) begin
      body = {tseq, v ? c : 8'h00, v ? d : 64'h0};
      ef   = {body, CRC_EN ? crc_ref(body) : 8'h00};
      tseq = tseq + 4'd1;
    end else begin
      ef   = '0;
      tseq = 4'd0;
    end
    tx_exp_q.push_back(ef);
    @(negedge clk);
    check_eq("tx_frame", tx_frame, tx_exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // RX monitor: every strobe must match the oldest expected payload.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rx_unexp_valid", rx_valid, 1'b0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("rx_payload", {rx_cmd, rx_data}, mon_exp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    link     = 1'b0;
    rxr      = 1'b0;
    txr      = 1'b0;
    rx_frame = '0;
    tx_data  = '0;
    tx_cmd   = '0;
    tx_valid = 1'b1;
    clear    = 1'b0;
    rseq     = 4'd0;
    tseq     = 4'd0;
    exp_crc  = 0;
    exp_seqe = 0;
    last_pl  = '0;
    held_pl  = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_locked", locked, 1'b0);
    check_eq("rst_rx_payload", {rx_cmd, rx_data}, 72'h0);
    check_eq("rst_tx_frame", tx_frame, 84'h0);
    check_eq("rst_tx_accept", tx_accept, 1'b0);
    check_eq("rst_crc_cnt", crc_cnt, 0);
    check_eq("rst_seq_cnt", seq_cnt, 0);
    check_eq("rst_state", rx_state, 2'd0);
    rst      = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);

    // Acquire lock with seq 0..3, then payload flows.
    link = 1'b1;
    rxr  = 1'b1;
    for (int i = 0; i < 4; i++) good(1'b0);
    check_eq("lock_not_yet", locked, 1'b0);
    good(1'b1);
    check_eq("lock_rise", locked, 1'b1);
    good(1'b1);
    good(1'b1);
    check_eq("tx_idle_while_off", tx_frame, 84'h0);

    // Single corrupted CRC while locked.
    bad_crc(!CRC_EN);
    exp_crc += CRC_EN ? 1 : 0;
    good(1'b1);
    check_eq("crc_cnt_one", crc_cnt, sat(exp_crc));
    check_eq("lock_hold_crc", locked, 1'b1);
    good(1'b1);

    // Single sequence slip while locked; the frame after it is good again.
    skip();
    exp_seqe += 1;
    good(1'b1);
    check_eq("seq_cnt_one", seq_cnt, sat(exp_seqe));
    check_eq("lock_hold_seq", locked, 1'b1);
    good(1'b1);

    // Eight consecutive bad frames drop lock; four good frames relock.
    for (int i = 0; i < 8; i++) skip();
    exp_seqe += 8;
    check_eq("lock_before_8th", locked, 1'b1);
    good(1'b0);
    check_eq("lock_lost", locked, 1'b0);
    good(1'b0);
    good(1'b0);
    good(1'b0);
    check_eq("relock_not_yet", locked, 1'b0);
    good(1'b1);
    check_eq("relock", locked, 1'b1);
    check_eq("seq_cnt_sat", seq_cnt, sat(exp_seqe));
    good(1'b1);

    // CRC counter saturation.
    for (int i = 0; i < 5; i++) bad_crc(!CRC_EN);
    exp_crc += CRC_EN ? 5 : 0;
    good(1'b1);
    check_eq("crc_cnt_sat", crc_cnt, sat(exp_crc));

    // Clear coincident with a sequence error wins.
    skip();
    clear = 1'b1;
    good(1'b1);
    clear = 1'b0;
    check_eq("clr_seq_cnt", seq_cnt, 0);
    check_eq("clr_crc_cnt", crc_cnt, 0);
    good(1'b1);
    check_eq("clr_seq_stays", seq_cnt, 0);

    // Link drop while locked: lock and strobe go away next clock, data holds.
    good(1'b1);
    held_pl = last_pl;
    good(1'b0);
    link = 1'b0;
    @(negedge clk);
    check_eq("drop_locked", locked, 1'b0);
    check_eq("drop_valid", rx_valid, 1'b0);
    check_eq("drop_state", rx_state, 2'd0);
    check_eq("drop_hold_data", {rx_cmd, rx_data}, held_pl);
    @(negedge clk);
    check_eq("drop_valid2", rx_valid, 1'b0);

    // TX path.
    rxr  = 1'b0;
    link = 1'b1;
    tx_cycle(1'b1, 1'b1, 8'hA5, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 20; i++) begin
      tx_cycle(1'b1, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)), {$urandom, $urandom});
    end
    tx_cycle(1'b0, 1'b1, 8'h11, 64'h1);
    tx_cycle(1'b0, 1'b0, 8'h22, 64'h2);
    tx_cycle(1'b1, 1'b0, 8'h33, 64'h3);
    tx_cycle(1'b1, 1'b1, 8'h44, 64'h4);
    link = 1'b0;
    tx_cycle(1'b1, 1'b1, 8'h55, 64'h5);
    link = 1'b1;
    tx_cycle(1'b1, 1'b1, 8'h66, 64'h6);
    tx_cycle(1'b1, 1'b0, 8'h77, 64'h7);

    repeat (2) @(negedge clk);
    check_eq("rx_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
